// File: rtl/mtl2_timer_scheduler_pkg.sv
// Shared definitions for the MTL2 interval-timer scheduler: register map,
// control bits, FSM states and the registered bus-write record.
package mtl2_timer_pkg;

    localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    // One-shot run: CONT stays clear so the timer stops itself after one timeout.
    localparam logic [15:0] CTRL_RUN_ONE_SHOT = (CTRL_START | CTRL_ITO) & ~CTRL_CONT;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CLR0,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_WR_STOP,
        ST_CLR1,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        cs;
        logic [2:0]  addr;
        logic [15:0] data;
    } tmr_wr_t;

    localparam tmr_wr_t TMR_BUS_IDLE = '{cs: 1'b0, addr: 3'd0, data: 16'd0};

    function automatic tmr_wr_t tmr_write(input logic [2:0] a, input logic [15:0] d);
        tmr_write = '{cs: 1'b1, addr: a, data: d};
    endfunction

endpackage

// File: rtl/mtl2_timer_scheduler_if.sv
// Avalon-MM write-only link between the scheduler (master) and the MTL2
// interval timer slave, plus the timer's irq line back to the scheduler.
interface mtl2_timer_scheduler_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input irq);
    modport slave  (input address, chipselect, write_n, writedata, output irq);
endinterface

// File: rtl/mtl2_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping to channel 0; grant is one-hot or zero.
module mtl2_rr_arbiter #(
    parameter int N_CH = 4,
    parameter int PW   = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [N_CH-1:0] grant
);

    logic found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < N_CH; off++) begin
            if (!found && req[(int'(rr_ptr) + off) % N_CH]) begin
                grant[(int'(rr_ptr) + off) % N_CH] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mtl2_timer_scheduler.sv
// Shares one MTL2 interval timer among N_CH one-shot delay requesters:
// round-robin grant, program timer, wait for irq (or cancel), pulse done.
module mtl2_timer_scheduler
    import mtl2_timer_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = 32,
    parameter int MIN_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH*DW-1:0]   req_delay,
    input  logic [N_CH-1:0]      cancel,
    output logic [N_CH-1:0]      grant,
    output logic [N_CH-1:0]      done,
    output logic                 done_cancelled,
    mtl2_timer_scheduler_if.master tmr
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t          state;
    tmr_wr_t         bus_q;
    logic [PW-1:0]   rr_ptr;
    logic [31:0]     load_q;
    logic            cancelled_q;

    logic [N_CH-1:0] arb_grant;
    logic [PW-1:0]   arb_next_ptr;
    logic [DW-1:0]   sel_delay;
    logic [31:0]     delay32;
    logic [31:0]     load_d;
    logic            cancel_hit;

    mtl2_rr_arbiter #(.N_CH(N_CH), .PW(PW)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant)
    );

    always_comb begin
        sel_delay    = '0;
        arb_next_ptr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_grant[i]) begin
                sel_delay    = req_delay[i*DW +: DW];
                arb_next_ptr = PW'((i + 1) % N_CH);
            end
        end
    end

    // Timer counts load..0, so a delay of D cycles needs load = D-1 (never 0).
    assign delay32 = 32'(sel_delay);
    assign load_d  = (delay32 < 32'(MIN_DELAY)) ? 32'(MIN_DELAY - 1) : delay32 - 32'd1;

    assign cancel_hit = (|(cancel & grant)) &&
                        (state inside {ST_CLR0, ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_WAIT_IRQ});

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state          <= ST_IDLE;
            grant          <= '0;
            done           <= '0;
            done_cancelled <= 1'b0;
            bus_q          <= TMR_BUS_IDLE;
            rr_ptr         <= '0;
            load_q         <= '0;
            cancelled_q    <= 1'b0;
        end else begin
            // NOTE: strobes default to idle each cycle, so a bus write and the
            // done pulse can never stretch beyond the one cycle that sets them.
            bus_q          <= TMR_BUS_IDLE;
            done           <= '0;
            done_cancelled <= 1'b0;

            if (cancel_hit) begin
                // The write already on the bus this cycle completes; STOP follows.
                bus_q       <= tmr_write(TMR_ADDR_CONTROL, CTRL_STOP);
                cancelled_q <= 1'b1;
                state       <= ST_WR_STOP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (|req) state <= ST_ARB;
                    end
                    ST_ARB: begin
                        if (|arb_grant) begin
                            grant       <= arb_grant;
                            load_q      <= load_d;
                            rr_ptr      <= arb_next_ptr;
                            cancelled_q <= 1'b0;
                            bus_q       <= tmr_write(TMR_ADDR_STATUS, 16'h0000);
                            state       <= ST_CLR0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_CLR0: begin
                        bus_q <= tmr_write(TMR_ADDR_PERIODL, load_q[15:0]);
                        state <= ST_WR_PL;
                    end
                    ST_WR_PL: begin
                        bus_q <= tmr_write(TMR_ADDR_PERIODH, load_q[31:16]);
                        state <= ST_WR_PH;
                    end
                    ST_WR_PH: begin
                        bus_q <= tmr_write(TMR_ADDR_CONTROL, CTRL_RUN_ONE_SHOT);
                        state <= ST_WR_CTRL;
                    end
                    ST_WR_CTRL: begin
                        state <= ST_WAIT_IRQ;
                    end
                    ST_WAIT_IRQ: begin
                        if (tmr.irq) begin
                            bus_q <= tmr_write(TMR_ADDR_STATUS, 16'h0000);
                            state <= ST_CLR1;
                        end
                    end
                    ST_WR_STOP: begin
                        bus_q <= tmr_write(TMR_ADDR_STATUS, 16'h0000);
                        state <= ST_CLR1;
                    end
                    ST_CLR1: begin
                        done           <= grant;
                        done_cancelled <= cancelled_q;
                        grant          <= '0;
                        state          <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tmr.chipselect = bus_q.cs;
    assign tmr.write_n    = ~bus_q.cs;
    assign tmr.address    = bus_q.addr;
    assign tmr.writedata  = bus_q.data;

endmodule

// File: tb/tb_mtl2_timer_scheduler.sv
// Directed bench for mtl2_timer_scheduler with a behavioural MTL2 timer on the
// bus; expected bus writes are queued at stimulus time and popped as they occur.
module tb_mtl2_timer_scheduler;

    localparam int N_CH      = 4;
    localparam int DW        = 32;
    localparam int MIN_DELAY = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [N_CH-1:0]      req = '0;
    logic [N_CH-1:0]      cancel = '0;
    logic [N_CH*DW-1:0]   req_delay = '0;
    logic [N_CH-1:0]      grant;
    logic [N_CH-1:0]      done;
    logic                 done_cancelled;

    mtl2_timer_scheduler_if tmr_bus ();

    mtl2_timer_scheduler #(.N_CH(N_CH), .DW(DW), .MIN_DELAY(MIN_DELAY)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_delay      (req_delay),
        .cancel         (cancel),
        .grant          (grant),
        .done           (done),
        .done_cancelled (done_cancelled),
        .tmr            (tmr_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural interval timer: START loads {period_h,period_l}, counts to 0,
    // then sets TO one cycle later (load+1 cycles after START).
    logic [15:0] t_pl, t_ph;
    logic [31:0] t_cnt;
    logic        t_ito, t_run, t_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= '0; t_ph <= '0; t_cnt <= '0;
            t_ito <= 1'b0; t_run <= 1'b0; t_to <= 1'b0;
        end else begin
            if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;
                    t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (tmr_bus.chipselect && !tmr_bus.write_n) begin
                case (tmr_bus.address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= tmr_bus.writedata[0];
                        if (tmr_bus.writedata[3]) t_run <= 1'b0;
                        else if (tmr_bus.writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= {t_ph, t_pl};
                        end
                    end
                    3'd2: t_pl <= tmr_bus.writedata;
                    3'd3: t_ph <= tmr_bus.writedata;
                    default: ;
                endcase
            end
        end
    end
    assign tmr_bus.irq = t_to & t_ito;

    int          tests_run = 0;
    int          failures  = 0;
    logic [18:0] exp_q[$];
    logic [18:0] exp_w;
    logic        irq_seen = 1'b0;
    logic        onehot_chk = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus scoreboard and per-cycle grant monitor.
    always @(negedge clk) begin
        if (tmr_bus.irq) irq_seen = 1'b1;
        if (onehot_chk) check("grant_onehot", 64'($onehot0(grant)), 64'd1);
        if (reset_n && tmr_bus.chipselect) begin
            if (exp_q.size() == 0) begin
                check("bus_extra_write_qdepth", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check("bus_write", {tmr_bus.write_n, tmr_bus.address, tmr_bus.writedata},
                      {1'b0, exp_w});
            end
        end
    end

    task automatic push_prog(input logic [31:0] d);
        logic [31:0] load;
        load = (d < MIN_DELAY) ? 32'(MIN_DELAY - 1) : d - 32'd1;
        exp_q.push_back({3'd0, 16'h0000});
        exp_q.push_back({3'd2, load[15:0]});
        exp_q.push_back({3'd3, load[31:16]});
        exp_q.push_back({3'd1, 16'h0005});
    endtask

    task automatic push_end(input logic cancelled);
        if (cancelled) exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd0, 16'h0000});
    endtask

    task automatic start_req(input int ch, input logic [31:0] d);
        req_delay[ch*DW +: DW] = d;
        req[ch] = 1'b1;
    endtask

    // Waits for a done pulse; the requester drops req/cancel in the DONE cycle.
    task automatic wait_done(input int budget, output logic [N_CH-1:0] ch_oh,
                             output logic canc, output int at_cyc);
        ch_oh = '0; canc = 1'b0; at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ch_oh  = done;
                canc   = done_cancelled;
                at_cyc = cyc;
                check("grant_low_in_done", 64'(grant), 64'd0);
                req    = req & ~done;
                cancel = cancel & ~done;
                @(negedge clk);
                check("done_single_pulse", 64'(done), 64'd0);
                return;
            end
        end
    endtask

    task automatic wait_prog(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_done_cancelled"}, 64'(done_cancelled), 64'd0);
        check({tag, "_cs"}, 64'(tmr_bus.chipselect), 64'd0);
        check({tag, "_write_n"}, 64'(tmr_bus.write_n), 64'd1);
        check({tag, "_address"}, 64'(tmr_bus.address), 64'd0);
        check({tag, "_writedata"}, 64'(tmr_bus.writedata), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        cancel = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N_CH-1:0] ch_oh;
        logic            canc;
        logic            ok;
        int              t0, at, lat, c_lat;

        c_lat = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Single request, D=100: measures the fixed overhead C.
        @(negedge clk);
        push_prog(32'd100);
        push_end(1'b0);
        start_req(0, 32'd100);
        t0 = cyc;
        wait_done(500, ch_oh, canc, at);
        check("d100_done_ch", 64'(ch_oh), 64'b0001);
        check("d100_not_cancelled", 64'(canc), 64'd0);
        c_lat = at - t0 - 100;
        check("overhead_c_in_range", 64'((c_lat >= 0) && (c_lat <= 10)), 64'd1);
        check("d100_queue_drained", 64'(exp_q.size()), 64'd0);

        // All four request at once from a fresh round-robin pointer.
        do_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            push_prog(32'd10);
            push_end(1'b0);
            req_delay[ch*DW +: DW] = 32'd10;
        end
        onehot_chk = 1'b1;
        req = '1;
        for (int k = 0; k < N_CH; k++) begin
            wait_done(200, ch_oh, canc, at);
            check("rr_all_done_order", 64'(ch_oh), 64'(1 << k));
        end
        onehot_chk = 1'b0;
        check("rr_all_queue_drained", 64'(exp_q.size()), 64'd0);

        // Cancel ch2 fifty cycles into WAIT_IRQ.
        push_prog(32'd1000);
        start_req(2, 32'd1000);
        wait_prog(100, ok);
        check("cancel_programmed", 64'(ok), 64'd1);
        irq_seen = 1'b0;
        repeat (50) @(negedge clk);
        check("cancel_grant_held", 64'(grant), 64'b0100);
        push_end(1'b1);
        cancel[2] = 1'b1;
        wait_done(100, ch_oh, canc, at);
        check("cancel_done_ch", 64'(ch_oh), 64'b0100);
        check("cancel_done_cancelled", 64'(canc), 64'd1);
        repeat (20) @(negedge clk);
        check("cancel_irq_never", 64'(irq_seen), 64'd0);
        check("cancel_queue_drained", 64'(exp_q.size()), 64'd0);

        // Clamping of short delays and a delay spanning period_h.
        push_prog(32'd0);
        push_end(1'b0);
        start_req(1, 32'd0);
        t0 = cyc;
        wait_done(100, ch_oh, canc, at);
        check("d0_done_ch", 64'(ch_oh), 64'b0010);
        check("d0_latency", 64'(at - t0), 64'(MIN_DELAY + c_lat));

        push_prog(32'd1);
        push_end(1'b0);
        start_req(1, 32'd1);
        t0 = cyc;
        wait_done(100, ch_oh, canc, at);
        check("d1_done_ch", 64'(ch_oh), 64'b0010);
        check("d1_latency", 64'(at - t0), 64'(MIN_DELAY + c_lat));

        push_prog(32'h0001_0005);
        push_end(1'b0);
        start_req(3, 32'h0001_0005);
        t0 = cyc;
        wait_done(70000, ch_oh, canc, at);
        check("dbig_done_ch", 64'(ch_oh), 64'b1000);
        lat = at - t0;
        check("dbig_latency", 64'(lat), 64'(65541 + c_lat));
        check("clamp_queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset while waiting on the timer; no cleanup writes may follow.
        push_prog(32'd1000);
        start_req(0, 32'd1000);
        wait_prog(100, ok);
        check("rst_programmed", 64'(ok), 64'd1);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_writes", 64'(exp_q.size()), 64'd0);
        push_prog(32'd20);
        push_end(1'b0);
        start_req(0, 32'd20);
        t0 = cyc;
        wait_done(200, ch_oh, canc, at);
        check("postrst_done_ch", 64'(ch_oh), 64'b0001);
        check("postrst_latency", 64'(at - t0), 64'(20 + c_lat));

        // Fairness: ch1 re-requests immediately, but waiting ch3 goes first.
        do_reset();
        push_prog(32'd10);
        push_end(1'b0);
        push_prog(32'd12);
        push_end(1'b0);
        req_delay[1*DW +: DW] = 32'd10;
        req_delay[3*DW +: DW] = 32'd12;
        req = 4'b1010;
        wait_done(200, ch_oh, canc, at);
        check("b2b_first", 64'(ch_oh), 64'b0010);
        push_prog(32'd10);
        push_end(1'b0);
        req[1] = 1'b1;
        wait_done(200, ch_oh, canc, at);
        check("b2b_second", 64'(ch_oh), 64'b1000);
        wait_done(200, ch_oh, canc, at);
        check("b2b_third", 64'(ch_oh), 64'b0010);
        check("final_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
